// File: rtl/bram_line_streamer.sv
// bram_line_streamer
//   Streams a contiguous range of lines out of a registered-read line RAM.
//   Each LINE_W line is split into LINE_W/BEAT_W beats on a valid/ready
//   stream, least-significant beat first. Reads are issued ahead into a
//   2-entry line buffer so the stream runs at one beat per cycle when the
//   sink never stalls, and no data is lost when it does.
//
// Ports
//   clk, rstn   clock, asynchronous active-low reset
//   start       command strobe (only honoured in IDLE)
//   base_addr   first line address of the command
//   num_lines   number of lines, 0..2^ADDR_W
//   busy        command in progress (RUN state)
//   done        one-cycle completion pulse
//   ram_addr    RAM read address (RAM registers it; data one cycle later)
//   ram_dout    RAM read data
//   m_data      output beat
//   m_valid     output beat valid
//   m_ready     sink ready
//   m_last      final beat of the command
module bram_line_streamer #(
    parameter int ADDR_W = 10,
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_lines,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [LINE_W-1:0] ram_dout,
    output logic [BEAT_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last
);

    localparam int BEATS = LINE_W / BEAT_W;
    localparam int KW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  num_q;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  popped;
    logic              inflight;

    logic [LINE_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_count;
    logic [KW-1:0]     beat_idx;

    logic [BEATS-1:0][BEAT_W-1:0] head_beats;

    logic start_ok;
    logic issue;
    logic push;
    logic hs;
    logic pop;
    logic beat_end;
    logic last_line;

    assign start_ok = (state == IDLE) && start;

    // A read is only issued when a buffer slot is guaranteed free for its
    // data, counting the line already in flight. The capture of ram_dout is
    // then unconditional and can never overflow the buffer.
    assign issue = (state == RUN) && (issued < num_q) &&
                   ((fifo_count + {1'b0, inflight}) < 2'd2);

    assign push     = inflight;
    assign m_valid  = (fifo_count != 2'd0);
    assign hs       = m_valid && m_ready;
    assign beat_end = (beat_idx == KW'(BEATS - 1));
    assign pop      = hs && beat_end;

    // Head line is the popped-th line of the command.
    assign last_line = (popped == (num_q - CNT_W'(1)));
    assign m_last    = m_valid && beat_end && last_line;

    assign head_beats = fifo_mem[rd_ptr];
    // Gated so the stale head slot does not leak onto m_data when idle.
    assign m_data     = m_valid ? head_beats[beat_idx] : '0;

    // Address is presented combinationally in the issuing cycle so the RAM
    // registers it at that edge; otherwise the last issued address is held.
    assign ram_addr = issue ? (base_q + issued[ADDR_W-1:0]) : addr_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (num_lines == '0) ? FLUSH : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (hs && m_last) state_nxt = FLUSH;
            end
            FLUSH: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- command / issue / buffer control ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q     <= '0;
            num_q      <= '0;
            addr_q     <= '0;
            issued     <= '0;
            popped     <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            beat_idx   <= '0;
        end else if (start_ok) begin
            base_q     <= base_addr;
            num_q      <= num_lines;
            issued     <= '0;
            popped     <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
            beat_idx   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                issued <= issued + CNT_W'(1);
                addr_q <= ram_addr;
            end
            if (push) wr_ptr <= ~wr_ptr;
            if (hs)   beat_idx <= beat_idx + KW'(1);
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                popped <= popped + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Line storage needs no reset: nothing reads a slot before it is written.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ram_dout;
    end

endmodule

// File: tb/tb_bram_line_streamer.sv
module tb_bram_line_streamer;

    localparam int ADDR_W = 10;
    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   num_lines = '0;
    logic              busy, done;
    logic [ADDR_W-1:0] ram_addr;
    logic [LINE_W-1:0] ram_dout;
    logic [BEAT_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;

    bram_line_streamer #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .num_lines(num_lines), .busy(busy), .done(done), .ram_addr(ram_addr),
        .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // beat j of line l
    function automatic logic [63:0] beat_pat(int l, int j);
        return {16'(l), 16'(j), 32'hCAFE0000 + 32'(l * 16 + j)};
    endfunction

    // RAM model: registered address, data valid the cycle after
    logic [LINE_W-1:0] mem [DEPTH];
    initial begin
        for (int l = 0; l < DEPTH; l++)
            for (int j = 0; j < 4; j++)
                mem[l][64*j +: 64] = beat_pat(l, j);
    end
    always @(posedge clk) ram_dout <= mem[ram_addr];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // sink readiness: held at 1 or driven from a seeded xorshift
    bit          rnd_ready = 1'b0;
    logic [31:0] lfsr = 32'h1234_5678;
    initial m_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        lfsr = lfsr ^ (lfsr << 13);
        lfsr = lfsr ^ (lfsr >> 17);
        lfsr = lfsr ^ (lfsr << 5);
        m_ready = rnd_ready ? lfsr[7] : 1'b1;
    end

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } exp_t;
    exp_t q[$];
    exp_t e;

    int          t_start = 0;
    int          cmd_n = 0;
    bit          cmd_active = 1'b0;
    int          exp_done_cyc = -1;
    int          hs_cnt = 0;
    int          first_valid_rel = -1;
    int          last_hs_rel = -1;
    int          done_rel = -1;
    logic [63:0] first_data = '0;
    logic [63:0] last_data = '0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data = '0;
    logic        prev_last = 1'b0;
    bit          exp_busy;

    always @(negedge clk) begin
        if (rstn) begin
            exp_busy = cmd_active && (cmd_n != 0) && (cyc > t_start) &&
                       (exp_done_cyc < 0 || cyc < exp_done_cyc);
            chk("busy", busy, exp_busy);
            chk("done", done, cyc == exp_done_cyc);
            if (cyc == exp_done_cyc) begin
                done_rel     = cyc - t_start;
                cmd_active   = 1'b0;
                exp_done_cyc = -1;
            end
            if (prev_stall) begin
                chk("hold_valid", m_valid, 1'b1);
                chk("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (m_valid) begin
                if (first_valid_rel < 0) first_valid_rel = cyc - t_start;
                if (q.size() == 0) begin
                    chk("extra_beat_valid", m_valid, 1'b0);
                end else begin
                    chk("beat_data", m_data, q[0].d);
                    chk("beat_last", m_last, q[0].l);
                    if (m_ready) begin
                        e = q.pop_front();
                        hs_cnt++;
                        if (hs_cnt == 1) first_data = m_data;
                        if (e.l) begin
                            exp_done_cyc = cyc + 1;
                            last_hs_rel  = cyc - t_start;
                            last_data    = m_data;
                        end
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // ram_addr change log (issue sequence)
    bit                log_en = 1'b0;
    logic [ADDR_W-1:0] last_ra = '0;
    int                addr_log[$];
    always @(negedge clk) begin
        if (rstn && log_en && ram_addr != last_ra) begin
            addr_log.push_back(int'(ram_addr));
            last_ra = ram_addr;
        end
    end

    // called at posedge+1; the next edge accepts the start
    task automatic run_cmd(input int b, input int n);
        base_addr       = ADDR_W'(b);
        num_lines       = (ADDR_W + 1)'(n);
        start           = 1'b1;
        t_start         = cyc;
        cmd_n           = n;
        cmd_active      = 1'b1;
        hs_cnt          = 0;
        first_valid_rel = -1;
        last_hs_rel     = -1;
        done_rel        = -1;
        q.delete();
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 4; j++)
                q.push_back('{d: beat_pat((b + i) % DEPTH, j), l: (i == n - 1 && j == 3)});
        exp_done_cyc = (n == 0) ? cyc + 1 : -1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (cmd_active && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk("cmd_timeout", cmd_active, 1'b0);
        if (cmd_active) begin
            q.delete();
            cmd_active   = 1'b0;
            exp_done_cyc = -1;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_addr"}, ram_addr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: three lines, no backpressure
        run_cmd(5, 3);
        wait_idle(100);
        chk("t1_first_valid_cycle", first_valid_rel, 3);
        chk("t1_last_beat_cycle", last_hs_rel, 14);
        chk("t1_done_cycle", done_rel, 15);
        chk("t1_beats", hs_cnt, 12);
        chk("t1_first_beat", first_data, 64'h0005_0000_CAFE_0050);
        chk("t1_last_beat", last_data, 64'h0007_0003_CAFE_0073);

        // 2: same command with random backpressure
        repeat (2) @(posedge clk);
        #1;
        rnd_ready = 1'b1;
        run_cmd(5, 3);
        wait_idle(600);
        chk("t2_beats", hs_cnt, 12);
        rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 3: address wrap
        last_ra = ram_addr;
        addr_log.delete();
        log_en = 1'b1;
        run_cmd(1022, 4);
        wait_idle(100);
        log_en = 1'b0;
        chk("t3_issue_count", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            chk("t3_issue0", addr_log[0], 1022);
            chk("t3_issue1", addr_log[1], 1023);
            chk("t3_issue2", addr_log[2], 0);
            chk("t3_issue3", addr_log[3], 1);
        end
        chk("t3_beats", hs_cnt, 16);
        @(posedge clk); #1;

        // 4: zero-length command, then start again in cycle 2
        run_cmd(0, 0);
        @(posedge clk); #1;
        chk("t4_zero_done_cycle", done_rel, 1);
        chk("t4_zero_beats", hs_cnt, 0);
        run_cmd(100, 2);
        wait_idle(100);
        chk("t4_beats", hs_cnt, 8);
        chk("t4_last_beat_cycle", last_hs_rel, 10);
        chk("t4_done_cycle", done_rel, 11);
        @(posedge clk); #1;

        // 5a: start during a command is ignored
        run_cmd(200, 4);
        repeat (3) @(posedge clk);
        #1;
        base_addr = 10'd50;
        num_lines = 11'd9;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(100);
        chk("t5_ignored_start_beats", hs_cnt, 16);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_restart_valid", m_valid, 0);

        // 5b: reset mid-command
        run_cmd(300, 4);
        k = 0;
        while (hs_cnt < 6 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t5_reached_beat6", hs_cnt >= 6, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        q.delete();
        cmd_active   = 1'b0;
        exp_done_cyc = -1;
        prev_stall   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        run_cmd(300, 4);
        wait_idle(100);
        chk("t5_fresh_beats", hs_cnt, 16);
        chk("t5_fresh_done_cycle", done_rel, 19);
        @(posedge clk); #1;

        // 6: full RAM sweep
        run_cmd(0, 1024);
        wait_idle(5000);
        chk("t6_beats", hs_cnt, 4096);
        chk("t6_last_beat_cycle", last_hs_rel, 4098);
        chk("t6_done_cycle", done_rel, 4099);
        chk("t6_last_beat", last_data, 64'h03FF_0003_CAFE_3FF3);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
